// File: rtl/led_pwm_driver.sv
// led_pwm_driver: captures the latched GRB word and drives double-buffered 8-bit PWM for an RGB LED.
// Define LED_PWM_GAMMA_EN to map each channel through a square-law curve when loading duties.
module led_pwm_driver #(
    parameter int PRESCALE      = 4,
    parameter int BLANK_TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [23:0] i_led_data,
    input  logic        i_passthru_en,
    output logic        o_pwm_r,
    output logic        o_pwm_g,
    output logic        o_pwm_b,
    output logic        o_update,
    output logic        o_blanked
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (BLANK_TIMEOUT > 0) ? $clog2(BLANK_TIMEOUT + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(BLANK_TIMEOUT);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic          pt_q;
    logic          capture;
    logic [PW-1:0] presc;
    logic          tick;
    logic [7:0]    pwm_cnt;
    logic          boundary;
    logic [23:0]   pending;
    logic          pending_flag;
    logic          load;
    logic [23:0]   load_word;
    logic [IW-1:0] idle;
    logic [IW-1:0] idle_next;
    logic          timeout;
    logic [0:0]    state;
    logic [7:0]    duty_r;
    logic [7:0]    duty_g;
    logic [7:0]    duty_b;

`ifdef LED_PWM_GAMMA_EN
    function automatic logic [7:0] map_duty(input logic [7:0] x);
        logic [15:0] sq;
        sq = {8'd0, x} * {8'd0, x};
        return (x == 8'hFF) ? 8'hFF : sq[15:8];
    endfunction
`else
    function automatic logic [7:0] map_duty(input logic [7:0] x);
        return x;
    endfunction
`endif

    assign capture   = i_passthru_en & ~pt_q;
    assign tick      = (presc == PRESC_LAST);
    assign boundary  = tick && (pwm_cnt == 8'hFF);
    assign load      = boundary && (capture || pending_flag);
    // A capture landing on the boundary bypasses the pending register entirely.
    assign load_word = capture ? i_led_data : pending;
    assign idle_next = (idle == IDLE_LIMIT) ? idle : idle + IW'(1);
    assign timeout   = (BLANK_TIMEOUT != 0) && (idle_next == IDLE_LIMIT);
    assign o_blanked = (state == ST_BLANK);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pt_q    <= 1'b0;
            presc   <= '0;
            pwm_cnt <= 8'd0;
        end else begin
            pt_q    <= i_passthru_en;
            presc   <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending      <= 24'd0;
            pending_flag <= 1'b0;
        end else if (load) begin
            pending_flag <= 1'b0;
        end else if (capture) begin
            pending      <= i_led_data;
            pending_flag <= 1'b1;
        end
    end

    // Active duties change only at a period boundary so a PWM cycle is never cut short.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_BLANK;
            idle     <= '0;
            duty_r   <= 8'd0;
            duty_g   <= 8'd0;
            duty_b   <= 8'd0;
            o_update <= 1'b0;
        end else begin
            o_update <= load;
            if (load) begin
                duty_g <= map_duty(load_word[23:16]);
                duty_r <= map_duty(load_word[15:8]);
                duty_b <= map_duty(load_word[7:0]);
                idle   <= '0;
                state  <= ST_RUN;
            end else if (boundary) begin
                idle <= idle_next;
                if (state == ST_RUN && timeout) begin
                    state  <= ST_BLANK;
                    duty_r <= 8'd0;
                    duty_g <= 8'd0;
                    duty_b <= 8'd0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_pwm_r <= 1'b0;
            o_pwm_g <= 1'b0;
            o_pwm_b <= 1'b0;
        end else begin
            o_pwm_r <= (state == ST_RUN) && (pwm_cnt < duty_r);
            o_pwm_g <= (state == ST_RUN) && (pwm_cnt < duty_g);
            o_pwm_b <= (state == ST_RUN) && (pwm_cnt < duty_b);
        end
    end
endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: directed scoreboard bench for led_pwm_driver with PRESCALE=1, BLANK_TIMEOUT=2.
// Honours LED_PWM_GAMMA_EN in its expected-duty model.
module tb_led_pwm_driver;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] i_led_data;
    logic        i_passthru_en;
    logic        o_pwm_r;
    logic        o_pwm_g;
    logic        o_pwm_b;
    logic        o_update;
    logic        o_blanked;

    int          checks = 0;
    int          failures = 0;
    int          cyc;
    logic [23:0] sb[$];
    bit          model_pending = 1'b0;

    led_pwm_driver #(.PRESCALE(1), .BLANK_TIMEOUT(2)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_led_data    (i_led_data),
        .i_passthru_en (i_passthru_en),
        .o_pwm_r       (o_pwm_r),
        .o_pwm_g       (o_pwm_g),
        .o_pwm_b       (o_pwm_b),
        .o_update      (o_update),
        .o_blanked     (o_blanked)
    );

    always #5 clk = ~clk;

    // With PRESCALE=1 this cycle count is the expected PWM position.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    function automatic int model_duty(input logic [7:0] x);
`ifdef LED_PWM_GAMMA_EN
        if (x == 8'hFF) return 255;
        return (int'(x) * int'(x)) / 256;
`else
        return int'(x);
`endif
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Pulses passthru for one cycle; an unapplied pending entry is replaced (latest wins).
    task automatic applyStimulus(input logic [23:0] word);
        i_led_data    = word;
        i_passthru_en = 1'b1;
        if (model_pending) void'(sb.pop_back());
        sb.push_back(word);
        model_pending = 1'b1;
        @(negedge clk);
        i_passthru_en = 1'b0;
    endtask

    task automatic waitUpdate(input int budget, output logic [23:0] word);
        int n = 0;
        while (o_update !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("update_seen", int'(o_update === 1'b1), 1);
        word = (sb.size() > 0) ? sb.pop_front() : 24'd0;
        model_pending = 1'b0;
    endtask

    task automatic measurePeriod(output int g, output int r, output int b, output int u);
        g = 0; r = 0; b = 0; u = 0;
        repeat (256) begin
            @(negedge clk);
            g += int'(o_pwm_g === 1'b1);
            r += int'(o_pwm_r === 1'b1);
            b += int'(o_pwm_b === 1'b1);
            u += int'(o_update === 1'b1);
        end
    endtask

    task automatic checkDuties(input string tag, input logic [23:0] w, input int g, input int r, input int b);
        checkOutput({tag, "_g"}, g, model_duty(w[23:16]));
        checkOutput({tag, "_r"}, r, model_duty(w[15:8]));
        checkOutput({tag, "_b"}, b, model_duty(w[7:0]));
    endtask

    initial begin
        logic [23:0] w;
        int g, r, b, u, nb, n, t_upd;

        rst_n         = 1'b1;
        i_passthru_en = 1'b0;
        i_led_data    = 24'd0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_pwm", int'({o_pwm_r, o_pwm_g, o_pwm_b}), 0);
        checkOutput("rst_update", int'(o_update), 0);
        checkOutput("rst_blanked", int'(o_blanked), 1);
        rst_n = 1'b1;

        // Two silent periods straight after reset
        nb = 0; g = 0; r = 0; b = 0; u = 0;
        repeat (512) begin
            @(negedge clk);
            g += int'(o_pwm_g !== 1'b0);
            r += int'(o_pwm_r !== 1'b0);
            b += int'(o_pwm_b !== 1'b0);
            u += int'(o_update !== 1'b0);
            nb += int'(o_blanked !== 1'b1);
        end
        checkOutput("idle_pwm", g + r + b, 0);
        checkOutput("idle_update", u, 0);
        checkOutput("idle_not_blanked", nb, 0);

        // Single capture mid-period
        applyStimulus(24'h80FF00);
        waitUpdate(600, w);
        checkOutput("run_blanked", int'(o_blanked), 0);
        measurePeriod(g, r, b, u);
        checkDuties("single", w, g, r, b);
        checkOutput("single_upd_count", u, 0);

        // Two captures in one period: only the latest is applied
        applyStimulus(24'h010203);
        repeat (5) @(negedge clk);
        applyStimulus(24'h0A0B0C);
        waitUpdate(600, w);
        measurePeriod(g, r, b, u);
        checkDuties("latest", w, g, r, b);
        checkOutput("latest_upd_count", u, 0);

        // Capture on the boundary cycle itself
        n = 0;
        while ((cyc % 256) != 255 && n < 600) begin
            @(negedge clk);
            n++;
        end
        i_led_data    = 24'h336699;
        i_passthru_en = 1'b1;
        sb.push_back(24'h336699);
        @(negedge clk);
        i_passthru_en = 1'b0;
        checkOutput("boundary_update", int'(o_update), 1);
        w = (sb.size() > 0) ? sb.pop_front() : 24'd0;
        t_upd = cyc;
        measurePeriod(g, r, b, u);
        checkDuties("boundary", w, g, r, b);
        checkOutput("boundary_flag_clear", u, 0);

        // Watchdog: blank at the second silent boundary
        n = 0;
        while (o_blanked !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        checkOutput("blank_cycle", cyc - t_upd, 512);
        measurePeriod(g, r, b, u);
        checkOutput("blank_pwm", g + r + b, 0);
        checkOutput("blank_upd", u, 0);
        checkOutput("blank_state", int'(o_blanked), 1);

        applyStimulus(24'hFF0040);
        waitUpdate(600, w);
        checkOutput("restore_blanked", int'(o_blanked), 0);
        measurePeriod(g, r, b, u);
        checkDuties("restore", w, g, r, b);

        // Asynchronous reset mid-period discards pending data
        applyStimulus(24'hFFFFFF);
        repeat (100) @(negedge clk);
        checkOutput("pre_reset_g", int'(o_pwm_g), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_pwm", int'({o_pwm_r, o_pwm_g, o_pwm_b}), 0);
        checkOutput("async_rst_blanked", int'(o_blanked), 1);
        sb.delete();
        model_pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nb = 0; g = 0; u = 0;
        repeat (600) begin
            @(negedge clk);
            g += int'({o_pwm_r, o_pwm_g, o_pwm_b} !== 3'b000);
            u += int'(o_update !== 1'b0);
            nb += int'(o_blanked !== 1'b1);
        end
        checkOutput("post_rst_pwm", g, 0);
        checkOutput("post_rst_update", u, 0);
        checkOutput("post_rst_not_blanked", nb, 0);

        // Passthru held high: one capture, later data changes ignored
        i_led_data    = 24'h112233;
        i_passthru_en = 1'b1;
        sb.push_back(24'h112233);
        model_pending = 1'b1;
        repeat (20) @(negedge clk);
        i_led_data = 24'h445566;
        waitUpdate(600, w);
        measurePeriod(g, r, b, u);
        checkDuties("held", w, g, r, b);
        checkOutput("held_upd_count", u, 0);
        i_passthru_en = 1'b0;

        checkOutput("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
